// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU request arbiter.
// Holds the control FSM states, ALU mode codes and the latched payloads.
package alu_ctrl_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned MODE_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        READ = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [MODE_W-1:0] MODE_ADD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_ADC = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SUB = 3'b010;
    localparam logic [MODE_W-1:0] MODE_INC = 3'b011;
    localparam logic [MODE_W-1:0] MODE_DEC = 3'b100;
    localparam logic [MODE_W-1:0] MODE_AND = 3'b101;
    localparam logic [MODE_W-1:0] MODE_OR  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_XOR = 3'b111;

    // Operation captured on accept.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [MODE_W-1:0] mode;
        logic              id;
    } op_t;

    // Response captured at the end of READ.
    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] data;
        logic              zero;
        logic              carry;
    } rsp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter: combinational grant plus a priority pointer that
// moves away from the winner after each accept when round-robin is enabled.
module rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_0_i,
    input  logic valid_1_i,
    input  logic en_i,
    input  logic accept_i,
    output logic grant_idx_c_o,
    output logic grant_vld_c_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        grant_idx_c_o = 1'b0;
        if (valid_0_i && valid_1_i) begin
            grant_idx_c_o = ptr_q;
        end else if (valid_1_i) begin
            grant_idx_c_o = 1'b1;
        end
        grant_vld_c_o = en_i && (valid_0_i || valid_1_i);

        ptr_d = ptr_q;
        if (RR_EN && accept_i) begin
            ptr_d = ~grant_idx_c_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared tri-state ALU and sequences
// each operation through execute, bus read and a held response.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_0,
    input  logic              req_valid_1,
    output logic              req_ready_0,
    output logic              req_ready_1,
    input  logic [DATA_W-1:0] req_a_0,
    input  logic [DATA_W-1:0] req_a_1,
    input  logic [DATA_W-1:0] req_b_0,
    input  logic [DATA_W-1:0] req_b_1,
    input  logic [MODE_W-1:0] req_mode_0,
    input  logic [MODE_W-1:0] req_mode_1,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [MODE_W-1:0] alu_mode,
    output logic              alu_ee,
    output logic              alu_eo,
    input  logic [DATA_W-1:0] alu_bus,
    input  logic              alu_flag_zero,
    input  logic              alu_flag_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_carry
);

    state_e state_q, state_d;
    op_t    op_q, op_d;
    rsp_t   rsp_q, rsp_d;
    logic   ee_q, ee_d, eo_q, eo_d, vld_q, vld_d;
    logic   arb_en, grant_idx, grant_vld, accept;

    // Ready is gated by rst_n so nothing is offered while reset is held.
    assign arb_en      = (state_q == IDLE) && rst_n;
    assign req_ready_0 = grant_vld && !grant_idx;
    assign req_ready_1 = grant_vld && grant_idx;
    assign accept      = (req_valid_0 && req_ready_0) || (req_valid_1 && req_ready_1);

    rr_arb2 #(
        .RR_EN(RR_EN)
    ) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_0_i    (req_valid_0),
        .valid_1_i    (req_valid_1),
        .en_i         (arb_en),
        .accept_i     (accept),
        .grant_idx_c_o(grant_idx),
        .grant_vld_c_o(grant_vld)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rsp_d   = rsp_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d.a    = grant_idx ? req_a_1 : req_a_0;
                    op_d.b    = grant_idx ? req_b_1 : req_b_0;
                    op_d.mode = grant_idx ? req_mode_1 : req_mode_0;
                    op_d.id   = grant_idx;
                    state_d   = EXEC;
                end
            end
            EXEC: state_d = READ;
            READ: begin
                rsp_d.id    = op_q.id;
                rsp_d.data  = alu_bus;
                rsp_d.zero  = alu_flag_zero;
                rsp_d.carry = alu_flag_carry;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Strobes are registered from the next state so they line up with it.
        ee_d  = (state_d == EXEC);
        eo_d  = (state_d == READ);
        vld_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            rsp_q <= '0;
            ee_q  <= 1'b0;
            eo_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            op_q  <= op_d;
            rsp_q <= rsp_d;
            ee_q  <= ee_d;
            eo_q  <= eo_d;
            vld_q <= vld_d;
        end
    end

    assign alu_a     = op_q.a;
    assign alu_b     = op_q.b;
    assign alu_mode  = op_q.mode;
    assign alu_ee    = ee_q;
    assign alu_eo    = eo_q;
    assign rsp_valid = vld_q;
    assign rsp_id    = rsp_q.id;
    assign rsp_data  = rsp_q.data;
    assign rsp_zero  = rsp_q.zero;
    assign rsp_carry = rsp_q.carry;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural tri-state ALU and a
// response scoreboard filled when each request is driven.
module tb_alu_arbiter;
    import alu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid_0, req_valid_1, req_ready_0, req_ready_1;
    logic [7:0] req_a_0, req_a_1, req_b_0, req_b_1;
    logic [2:0] req_mode_0, req_mode_1;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_mode;
    logic       alu_ee, alu_eo;
    wire  [7:0] alu_bus;
    logic       alu_flag_zero, alu_flag_carry;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_carry;
    logic [7:0] rsp_data;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
        logic       z;
        logic       c;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   ee_cnt  = 0;
    logic [7:0] alu_res = 8'h00;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .req_mode_0(req_mode_0), .req_mode_1(req_mode_1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
        .alu_ee(alu_ee), .alu_eo(alu_eo), .alu_bus(alu_bus),
        .alu_flag_zero(alu_flag_zero), .alu_flag_carry(alu_flag_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry)
    );

    // Behavioural ALU: result register loaded on execute, driven onto the bus on eo.
    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] m, input logic cin);
        case (m)
            MODE_ADD: return {1'b0, a} + {1'b0, b};
            MODE_ADC: return {1'b0, a} + {1'b0, b} + {8'h00, cin};
            MODE_SUB: return {1'b0, a} - {1'b0, b};
            MODE_INC: return {1'b0, a} + 9'd1;
            MODE_DEC: return {1'b0, a} - 9'd1;
            MODE_AND: return {1'b0, a & b};
            MODE_OR:  return {1'b0, a | b};
            default:  return {1'b0, a ^ b};
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_ee) begin
            {alu_flag_carry, alu_res} <= alu_model(alu_a, alu_b, alu_mode, alu_flag_carry);
            alu_flag_zero <= ((alu_model(alu_a, alu_b, alu_mode, alu_flag_carry) & 9'h0FF) == 9'h000);
            ee_cnt <= ee_cnt + 1;
        end
    end

    assign alu_bus = alu_eo ? alu_res : 8'hzz;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic push_exp(input logic id, input logic [7:0] d, input logic z, input logic c);
        exp_t e;
        e.id = id; e.data = d; e.z = z; e.c = c;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_id"},    8'(rsp_id),    8'(e.id));
            check({tag, "_data"},  rsp_data,      e.data);
            check({tag, "_zero"},  8'(rsp_zero),  8'(e.z));
            check({tag, "_carry"}, 8'(rsp_carry), 8'(e.c));
        end
    endtask

    task automatic set_req(input logic id, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] m);
        if (id) begin
            req_a_1 = a; req_b_1 = b; req_mode_1 = m; req_valid_1 = 1'b1;
        end else begin
            req_a_0 = a; req_b_0 = b; req_mode_0 = m; req_valid_0 = 1'b1;
        end
    endtask

    // Waits for ready, lets the accept edge pass and returns at the negedge of T+1.
    task automatic accept(input logic id, input string tag);
        int   k = 0;
        logic rdy;
        #1;
        rdy = id ? req_ready_1 : req_ready_0;
        while (!rdy && k < 20) begin
            @(negedge clk); #1; k++;
            rdy = id ? req_ready_1 : req_ready_0;
        end
        check({tag, "_ready"}, 8'(rdy), 8'd1);
        @(negedge clk);
        if (id) req_valid_1 = 1'b0; else req_valid_0 = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge clk); k++;
        end
        check({tag, "_rsp_seen"}, 8'(rsp_valid), 8'd1);
    endtask

    // Both requesters valid until n accepts; responses checked as they appear.
    task automatic run_both(input int n, input string tag);
        int n_acc = 0;
        int n_rsp = 0;
        int cyc   = 0;
        bit drop  = 1'b0;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        while (n_rsp < n && cyc < 20 * n) begin
            #1;
            if (req_ready_0 || req_ready_1) begin
                n_acc++;
                if (n_acc == n) drop = 1'b1;
            end
            @(negedge clk); cyc++;
            if (drop) begin
                req_valid_0 = 1'b0; req_valid_1 = 1'b0; drop = 1'b0;
            end
            if (rsp_valid) begin
                pop_check(tag);
                n_rsp++;
            end
        end
        check({tag, "_count"}, 8'(n_rsp), 8'(n));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy0"},  8'(req_ready_0), 8'd0);
        check({tag, "_rdy1"},  8'(req_ready_1), 8'd0);
        check({tag, "_ee"},    8'(alu_ee),      8'd0);
        check({tag, "_eo"},    8'(alu_eo),      8'd0);
        check({tag, "_vld"},   8'(rsp_valid),   8'd0);
        check({tag, "_id"},    8'(rsp_id),      8'd0);
        check({tag, "_data"},  rsp_data,        8'd0);
        check({tag, "_zero"},  8'(rsp_zero),    8'd0);
        check({tag, "_carry"}, 8'(rsp_carry),   8'd0);
        check({tag, "_a"},     alu_a,           8'd0);
        check({tag, "_b"},     alu_b,           8'd0);
        check({tag, "_mode"},  8'(alu_mode),    8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  ee0;
        bit  saw_vld;
        rst_n = 1'b0; rsp_ready = 1'b1;
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        req_a_0 = 8'h00; req_a_1 = 8'h00; req_b_0 = 8'h00; req_b_1 = 8'h00;
        req_mode_0 = 3'b000; req_mode_1 = 3'b000;

        // Reset values, with a requester already valid.
        @(negedge clk);
        req_valid_0 = 1'b1;
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        req_valid_0 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single add with cycle-by-cycle latency.
        ee0 = ee_cnt;
        push_exp(1'b0, 8'h08, 1'b0, 1'b0);
        set_req(1'b0, 8'h05, 8'h03, MODE_ADD);
        #1;
        check("add_only_rdy1", 8'(req_ready_1), 8'd0);
        accept(1'b0, "add");
        check("add_t1_ee",   8'(alu_ee),    8'd1);
        check("add_t1_eo",   8'(alu_eo),    8'd0);
        check("add_t1_a",    alu_a,         8'h05);
        check("add_t1_b",    alu_b,         8'h03);
        check("add_t1_vld",  8'(rsp_valid), 8'd0);
        @(negedge clk);
        check("add_t2_ee",   8'(alu_ee),    8'd0);
        check("add_t2_eo",   8'(alu_eo),    8'd1);
        check("add_t2_a",    alu_a,         8'h05);
        check("add_t2_vld",  8'(rsp_valid), 8'd0);
        @(negedge clk);
        check("add_t3_vld",  8'(rsp_valid), 8'd1);
        check("add_t3_eo",   8'(alu_eo),    8'd0);
        pop_check("add");
        check("add_ee_once", 8'(ee_cnt - ee0), 8'd1);
        @(negedge clk);
        check("add_t4_vld",  8'(rsp_valid), 8'd0);

        // Carry out of add from requester 1.
        push_exp(1'b1, 8'h00, 1'b1, 1'b1);
        set_req(1'b1, 8'hFF, 8'h01, MODE_ADD);
        accept(1'b1, "carry");
        wait_rsp("carry");
        pop_check("carry");

        // Contention: pointer at 0, so 0,1,0,1.
        req_a_0 = 8'h10; req_b_0 = 8'h01; req_mode_0 = MODE_SUB;
        req_a_1 = 8'hF0; req_b_1 = 8'h0F; req_mode_1 = MODE_XOR;
        for (int i = 0; i < 2; i++) begin
            push_exp(1'b0, 8'h0F, 1'b0, 1'b0);
            push_exp(1'b1, 8'hFF, 1'b0, 1'b0);
        end
        run_both(4, "rr");

        // Backpressure on an inc, with requester 1 waiting.
        @(negedge clk);
        rsp_ready = 1'b0;
        push_exp(1'b0, 8'h00, 1'b1, 1'b1);
        set_req(1'b0, 8'hFF, 8'h00, MODE_INC);
        accept(1'b0, "bp");
        push_exp(1'b1, 8'h88, 1'b0, 1'b0);
        set_req(1'b1, 8'hCC, 8'hAA, MODE_AND);
        wait_rsp("bp");
        ee0 = ee_cnt;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_vld",  8'(rsp_valid),   8'd1);
            check("bp_hold_data", rsp_data,        8'h00);
            check("bp_hold_c",    8'(rsp_carry),   8'd1);
            check("bp_no_rdy1",   8'(req_ready_1), 8'd0);
            @(negedge clk);
        end
        check("bp_no_ee", 8'(ee_cnt - ee0), 8'd0);
        pop_check("bp");
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_vld",  8'(rsp_valid),   8'd0);
        check("bp_release_rdy1", 8'(req_ready_1), 8'd1);
        accept(1'b1, "and");
        wait_rsp("and");
        pop_check("and");
        @(negedge clk);

        // Reset during EXEC aborts the operation.
        set_req(1'b0, 8'h01, 8'h02, MODE_ADD);
        accept(1'b0, "abort");
        check("abort_in_exec", 8'(alu_ee), 8'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        saw_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            saw_vld = saw_vld | rsp_valid;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            saw_vld = saw_vld | rsp_valid;
        end
        check("abort_no_rsp", 8'(saw_vld), 8'd0);

        // Pointer is back at 0 after reset, so requester 0 wins first.
        req_a_0 = 8'h30; req_b_0 = 8'h03; req_mode_0 = MODE_OR;
        req_a_1 = 8'h0F; req_b_1 = 8'h0F; req_mode_1 = MODE_XOR;
        push_exp(1'b0, 8'h33, 1'b0, 1'b0);
        push_exp(1'b1, 8'h00, 1'b1, 1'b0);
        run_both(2, "post_rst");
        check("sb_drained", 8'(sb.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
